// File: rtl/clk_div_monitor_if.sv
// Interface bundling the stream under test and the monitor's results.
//   pulse_in     : divided clock / strobe under test (synchronous to clk)
//   period       : last measured rising-edge-to-rising-edge period, in clk cycles
//   period_valid : one-cycle pulse; period updated this cycle
//   locked       : high while the stream is in lock
//   err          : one-cycle pulse on a period mismatch or a timeout
//   err_cnt      : saturating count of err pulses
// Modports:
//   master : drives the stream and observes the results (stimulus side)
//   slave  : the monitor itself
interface clk_div_monitor_if #(
  parameter int CNT_W = 8,
  parameter int ERR_W = 8
);
  logic             pulse_in;
  logic [CNT_W-1:0] period;
  logic             period_valid;
  logic             locked;
  logic             err;
  logic [ERR_W-1:0] err_cnt;

  modport master (
    output pulse_in,
    input  period, period_valid, locked, err, err_cnt
  );

  modport slave (
    input  pulse_in,
    output period, period_valid, locked, err, err_cnt
  );
endinterface

// File: rtl/clk_div_monitor.sv
// Receive-side checker for a divided-clock / strobe stream.
// Measures the rising-edge-to-rising-edge period of pulse_in in clk cycles,
// compares it against DIV, declares lock after LOCK_N consecutive correct
// periods and flags mismatches and missing edges (timeout at 2*DIV cycles).
// Ports:
//   clk  : system clock
//   rst  : synchronous reset, active-high
//   bus  : clk_div_monitor_if.slave (pulse_in in; period, period_valid,
//          locked, err, err_cnt out)
// The interface instance must use the same CNT_W / ERR_W as this module.
module clk_div_monitor #(
  parameter int DIV    = 4,
  parameter int CNT_W  = 8,
  parameter int LOCK_N = 3,
  parameter int ERR_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  clk_div_monitor_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,  // waiting for the first edge
    HUNT   = 2'd1,  // measuring, not yet locked
    LOCKED = 2'd2   // stream in lock
  } state_t;

  localparam logic [CNT_W-1:0] DIV_C  = CNT_W'(DIV);
  localparam logic [CNT_W-1:0] TMO_C  = CNT_W'(2 * DIV);
  localparam logic [3:0]       LOCK_C = 4'(LOCK_N);

  state_t           state;
  logic             pulse_d;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       good_cnt;
  logic [3:0]       good_next;
  logic             rise;

  logic [CNT_W-1:0] period_q;
  logic             period_valid_q;
  logic             locked_q;
  logic             err_q;
  logic [ERR_W-1:0] err_cnt_q;

  assign rise      = bus.pulse_in & ~pulse_d;
  assign good_next = good_cnt + 4'd1;

  // NOTE: all state and registered outputs live in one clocked block using
  // non-blocking assignments, so every read of cnt/good_cnt/state below sees
  // the value from before this edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      // NOTE: pulse_d resets to 1 so a stream already high when reset is
      // released is not mistaken for a rising edge.
      pulse_d        <= 1'b1;
      cnt            <= '0;
      good_cnt       <= '0;
      period_q       <= '0;
      period_valid_q <= 1'b0;
      locked_q       <= 1'b0;
      err_q          <= 1'b0;
      err_cnt_q      <= '0;
    end else begin
      pulse_d        <= bus.pulse_in;
      period_valid_q <= 1'b0;
      err_q          <= 1'b0;

      unique case (state)
        IDLE: begin
          if (rise) begin
            cnt   <= CNT_W'(1);
            state <= HUNT;
          end
        end

        HUNT, LOCKED: begin
          if (rise) begin
            // A rise always wins over a coincident timeout: the edge is
            // reported with period = cnt (possibly 2*DIV, a mismatch).
            cnt            <= CNT_W'(1);
            period_q       <= cnt;
            period_valid_q <= 1'b1;
            if (cnt == DIV_C) begin
              if (state == HUNT) begin
                if (good_next == LOCK_C) begin
                  state    <= LOCKED;
                  locked_q <= 1'b1;
                  good_cnt <= '0;
                end else begin
                  good_cnt <= good_next;
                end
              end
            end else begin
              err_q    <= 1'b1;
              if (err_cnt_q != '1) err_cnt_q <= err_cnt_q + 1'b1;
              good_cnt <= '0;
              locked_q <= 1'b0;
              state    <= HUNT;
            end
          end else if (cnt == TMO_C) begin
            // Missing edge: give up on this stream and wait for a new edge.
            err_q    <= 1'b1;
            if (err_cnt_q != '1) err_cnt_q <= err_cnt_q + 1'b1;
            good_cnt <= '0;
            locked_q <= 1'b0;
            cnt      <= '0;
            state    <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.period       = period_q;
  assign bus.period_valid = period_valid_q;
  assign bus.locked       = locked_q;
  assign bus.err          = err_q;
  assign bus.err_cnt      = err_cnt_q;

endmodule

// File: tb/tb_clk_div_monitor.sv
// Self-checking bench for clk_div_monitor (DIV=4, LOCK_N=3, CNT_W=8, ERR_W=8).
// A timestamp-based model (time of last rising edge, run length of good
// periods) predicts the outputs after every clock edge; a compare process
// checks all outputs each cycle, and a few literal checks pin the model.
module tb_clk_div_monitor;

  localparam int DIV    = 4;
  localparam int CNT_W  = 8;
  localparam int LOCK_N = 3;
  localparam int ERR_W  = 8;
  localparam int ERR_MAX = (1 << ERR_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  clk_div_monitor_if #(.CNT_W(CNT_W), .ERR_W(ERR_W)) bus ();

  clk_div_monitor #(
    .DIV(DIV), .CNT_W(CNT_W), .LOCK_N(LOCK_N), .ERR_W(ERR_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int  t          = 0;    // index of the clock edge being modelled
  bit  prev_level = 1'b1;
  bit  have_ref   = 1'b0; // a previous rising edge is being timed from
  int  last_rise  = 0;
  int  good_run   = 0;
  bit  m_locked   = 1'b0;
  int  m_err_cnt  = 0;
  int  exp_period = 0;
  bit  exp_pv     = 1'b0;
  bit  exp_err    = 1'b0;
  bit  model_on   = 1'b0;

  function automatic void bump_err();
    exp_err = 1'b1;
    if (m_err_cnt < ERR_MAX) m_err_cnt++;
  endfunction

  // Predict the outputs visible after the next clock edge, given the inputs
  // presented to that edge.
  function automatic void model_step(input bit r, input bit p);
    bit r_edge;
    int elapsed;
    exp_pv  = 1'b0;
    exp_err = 1'b0;
    if (r) begin
      prev_level = 1'b1;
      have_ref   = 1'b0;
      good_run   = 0;
      m_locked   = 1'b0;
      m_err_cnt  = 0;
      exp_period = 0;
    end else begin
      r_edge     = p && !prev_level;
      prev_level = p;
      elapsed    = t - last_rise;
      if (r_edge) begin
        if (have_ref) begin
          exp_period = elapsed;
          exp_pv     = 1'b1;
          if (elapsed == DIV) begin
            if (!m_locked) begin
              good_run++;
              if (good_run == LOCK_N) begin
                m_locked = 1'b1;
                good_run = 0;
              end
            end
          end else begin
            bump_err();
            good_run = 0;
            m_locked = 1'b0;
          end
        end
        have_ref  = 1'b1;
        last_rise = t;
      end else if (have_ref && elapsed == 2 * DIV) begin
        bump_err();
        have_ref = 1'b0;
        good_run = 0;
        m_locked = 1'b0;
      end
    end
    t++;
  endfunction

  // ---------------- compare process ----------------
  always @(posedge clk) begin
    #1;
    if (model_on) begin
      check("period",       32'(bus.period),       32'(exp_period));
      check("period_valid", 32'(bus.period_valid), 32'(exp_pv));
      check("locked",       32'(bus.locked),       32'(m_locked));
      check("err",          32'(bus.err),          32'(exp_err));
      check("err_cnt",      32'(bus.err_cnt),      32'(m_err_cnt));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input bit r, input bit p);
    @(negedge clk);
    rst          = r;
    bus.pulse_in = p;
    model_step(r, p);
    model_on = 1'b1;
  endtask

  task automatic send_period(input int per, input int width);
    for (int i = 0; i < per; i++) step(1'b0, i < width);
  endtask

  task automatic idle_low(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  initial begin
    bus.pulse_in = 1'b1;

    // Reset with pulse_in held high; release with it still high.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    settle();
    check("no_rise_at_reset_exit_pv", 32'(bus.period_valid), 32'd0);
    check("no_rise_at_reset_exit_err", 32'(bus.err), 32'd0);
    step(1'b0, 1'b0);

    // Clean stream of period 4: lock after 3 matching periods.
    for (int i = 0; i < 5; i++) send_period(DIV, 1);
    settle();
    check("lit_locked_after_clean", 32'(bus.locked), 32'd1);
    check("lit_period_clean", 32'(bus.period), 32'd4);
    check("lit_errcnt_clean", 32'(bus.err_cnt), 32'd0);

    // One period of 5, then three good periods re-lock.
    send_period(5, 1);
    for (int i = 0; i < 4; i++) send_period(DIV, 1);
    settle();
    check("lit_relock_after_5", 32'(bus.locked), 32'd1);
    check("lit_errcnt_after_5", 32'(bus.err_cnt), 32'd1);

    // Stuck low: timeout at cnt == 8.
    idle_low(12);
    settle();
    check("lit_unlock_timeout", 32'(bus.locked), 32'd0);
    check("lit_errcnt_timeout", 32'(bus.err_cnt), 32'd2);
    for (int i = 0; i < 4; i++) send_period(DIV, 2);

    // Rise exactly at cnt == 8: one mismatch err, no extra timeout.
    send_period(2 * DIV, 1);
    send_period(DIV, 1);
    idle_low(0);
    settle();
    check("lit_errcnt_boundary", 32'(bus.err_cnt), 32'd3);
    check("lit_locked_boundary", 32'(bus.locked), 32'd0);

    // Reset for one cycle while locked, then reacquire.
    for (int i = 0; i < 4; i++) send_period(DIV, 1);
    step(1'b1, 1'b0);
    settle();
    check("lit_reset_locked", 32'(bus.locked), 32'd0);
    check("lit_reset_errcnt", 32'(bus.err_cnt), 32'd0);
    check("lit_reset_period", 32'(bus.period), 32'd0);
    for (int i = 0; i < 5; i++) send_period(DIV, 1);
    settle();
    check("lit_relock_after_reset", 32'(bus.locked), 32'd1);

    // Randomized stream: periods near DIV, up past the timeout, random widths,
    // occasional gaps and resets.
    for (int i = 0; i < 250; i++) begin
      int per;
      int sel;
      sel = int'($urandom_range(0, 9));
      per = (sel < 6) ? DIV : int'($urandom_range(2, 2 * DIV + 2));
      send_period(per, int'($urandom_range(1, per - 1)));
      if ($urandom_range(0, 39) == 0) idle_low(int'($urandom_range(1, 12)));
      if ($urandom_range(0, 59) == 0) step(1'b1, 1'($urandom_range(0, 1)));
    end

    // Saturation: clear, then 300 periods of 3.
    step(1'b1, 1'b0);
    for (int i = 0; i < 300; i++) send_period(3, 1);
    step(1'b0, 1'b1);
    settle();
    check("lit_errcnt_saturated", 32'(bus.err_cnt), 32'(ERR_MAX));
    check("lit_no_lock_period3", 32'(bus.locked), 32'd0);

    idle_low(2);
    settle();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
